// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, stall codes, bubble word and fetch FSM states.
package if_fetch_unit_pkg;
    localparam int STALL_WIDTH    = 2;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int REG_DATA_WIDTH = 32;
    localparam logic [STALL_WIDTH-1:0] STALL_NONE   = 2'd0;
    localparam logic [STALL_WIDTH-1:0] STALL_LOAD   = 2'd1;
    localparam logic [STALL_WIDTH-1:0] STALL_BRANCH = 2'd2;
    localparam logic [REG_DATA_WIDTH-1:0] NOP = '0;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} fetch_state_e;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory req/gnt/rvalid bus between fetch unit and memory.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;
    logic                      imem_req;
    logic [MEM_ADDR_WIDTH-1:0] imem_addr;
    logic                      imem_gnt;
    logic                      imem_rvalid;
    logic [REG_DATA_WIDTH-1:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

// File: rtl/if_fetch_unit_skid_buf.sv
// if_skid_buf: one-entry PC/instruction buffer; clear beats load, load beats drain.
module if_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic                      drain_i,
    input  logic                      clear_i,
    input  logic [MEM_ADDR_WIDTH-1:0] pc_i,
    input  logic [REG_DATA_WIDTH-1:0] inst_i,
    output logic                      valid_o,
    output logic [MEM_ADDR_WIDTH-1:0] pc_o,
    output logic [REG_DATA_WIDTH-1:0] inst_o
);
    logic                      valid_q;
    logic [MEM_ADDR_WIDTH-1:0] pc_q;
    logic [REG_DATA_WIDTH-1:0] inst_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= NOP;
        end else begin
            valid_q <= clear_i ? 1'b0 : load_i ? 1'b1 : drain_i ? 1'b0 : valid_q;
            if (load_i && !clear_i) begin
                pc_q   <= pc_i;
                inst_q <= inst_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch stage with one outstanding imem request, stall hold and branch redirect.
// Define IF_MISALIGN_CHK_EN to add fetch_misalign and word-align branch targets.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [MEM_ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int                        PC_INC   = 4
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [STALL_WIDTH-1:0]    stall,
    input  logic                      branch_taken,
    input  logic [MEM_ADDR_WIDTH-1:0] branch_target,
    if_fetch_unit_if.master           imem,
    output logic [MEM_ADDR_WIDTH-1:0] PC_if,
    output logic [REG_DATA_WIDTH-1:0] inst_if
`ifdef IF_MISALIGN_CHK_EN
    ,
    output logic                      fetch_misalign
`endif
);
    localparam logic [MEM_ADDR_WIDTH-1:0] INC = MEM_ADDR_WIDTH'(PC_INC);

    fetch_state_e              state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, pc_q, pc_d, target, skid_pc;
    logic [REG_DATA_WIDTH-1:0] inst_q, inst_d, skid_inst;
    logic                      discard_q, discard_d, hold, gnt_ok, accept;
    logic                      skid_load, skid_drain, skid_valid;

    assign hold   = (stall == STALL_LOAD) || (stall == STALL_BRANCH);
    assign gnt_ok = imem.imem_req && imem.imem_gnt;
    assign accept = state_q == S_WAIT && imem.imem_rvalid && !discard_q && !branch_taken;
`ifdef IF_MISALIGN_CHK_EN
    logic misalign_q;
    assign target         = {branch_target[MEM_ADDR_WIDTH-1:2], 2'b00};
    assign fetch_misalign = misalign_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) misalign_q <= 1'b0;
        else      misalign_q <= branch_taken && (branch_target[1:0] != 2'b00);
    end
`else
    assign target = branch_target;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // A redirect leaves a stale response in flight only if one is still owed.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        if (branch_taken) begin
            discard_d = (state_q == S_WAIT && !imem.imem_rvalid) || gnt_ok;
            state_d   = discard_d ? S_WAIT : S_REQ;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_REQ;
                S_REQ:  state_d = gnt_ok ? S_WAIT : S_REQ;
                S_WAIT: if (imem.imem_rvalid) begin
                    discard_d = 1'b0;
                    state_d   = (hold && !discard_q) ? S_HOLD : S_REQ;
                end
                S_HOLD: state_d = hold ? S_HOLD : S_REQ;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // The outstanding request's PC is fetch_pc - INC: fetch_pc only moves in S_WAIT on a redirect.
    always_comb begin
        imem.imem_req  = state_q == S_REQ && !hold;
        imem.imem_addr = fetch_pc_q;
        skid_load      = accept && hold;
        skid_drain     = state_q == S_HOLD && skid_valid && !hold && !branch_taken;
        fetch_pc_d     = branch_taken ? target : gnt_ok ? fetch_pc_q + INC : fetch_pc_q;
        pc_d           = (accept && !hold) ? fetch_pc_q - INC : skid_drain ? skid_pc : pc_q;
        inst_d         = branch_taken ? NOP
                       : (accept && !hold) ? imem.imem_rdata
                       : skid_drain ? skid_inst
                       : (state_q == S_REQ && !hold) ? NOP : inst_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            pc_q       <= '0;
            inst_q     <= NOP;
            discard_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            discard_q  <= discard_d;
        end
    end

    if_skid_buf u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .clear_i (branch_taken),
        .pc_i    (fetch_pc_q - INC),
        .inst_i  (imem.imem_rdata),
        .valid_o (skid_valid),
        .pc_o    (skid_pc),
        .inst_o  (skid_inst)
    );

    assign PC_if   = pc_q;
    assign inst_if = inst_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed vectors with hand-computed expectations for if_fetch_unit.
module tb_if_fetch_unit;
    import if_fetch_unit_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [STALL_WIDTH-1:0]    stall = STALL_NONE;
    logic                      branch_taken = 1'b0;
    logic [MEM_ADDR_WIDTH-1:0] branch_target = '0;
    logic [MEM_ADDR_WIDTH-1:0] PC_if;
    logic [REG_DATA_WIDTH-1:0] inst_if;
`ifdef IF_MISALIGN_CHK_EN
    logic                      fetch_misalign;
`endif
    int checks = 0;
    int errors = 0;

    if_fetch_unit_if imem ();

    if_fetch_unit u_dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem.master),
        .PC_if         (PC_if),
        .inst_if       (inst_if)
`ifdef IF_MISALIGN_CHK_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = '0;
        repeat (3) step();
        chk("rst_pc", PC_if, 32'h0);
        chk("rst_inst", inst_if, 32'h0);
        chk("rst_req", 32'(imem.imem_req), 32'h0);
        rst = 1'b1;
        chk("idle_req", 32'(imem.imem_req), 32'h0);
        step();
        chk("first_req", 32'(imem.imem_req), 32'h1);
        chk("first_addr", imem.imem_addr, 32'h0);
        // sequential fetches 0x0, 0x4, 0x8 with bubbles between
        for (int i = 0; i < 3; i++) begin
            imem.imem_gnt = 1'b1;
            step();
            imem.imem_gnt = 1'b0;
            chk("wait_req", 32'(imem.imem_req), 32'h0);
            if (i > 0) chk("bubble", inst_if, 32'h0);
            imem.imem_rvalid = 1'b1;
            imem.imem_rdata  = 32'h0000_0013;
            step();
            imem.imem_rvalid = 1'b0;
            chk("seq_pc", PC_if, 32'(i * 4));
            chk("seq_inst", inst_if, 32'h0000_0013);
            chk("seq_addr", imem.imem_addr, 32'(i * 4 + 4));
        end
        // load stall during S_WAIT, response captured in skid buffer
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        stall = STALL_LOAD;
        step();
        step();
        chk("stall_req", 32'(imem.imem_req), 32'h0);
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h00A0_0093;
        step();
        imem.imem_rvalid = 1'b0;
        chk("hold_pc", PC_if, 32'h8);
        chk("hold_inst", inst_if, 32'h0);
        chk("hold_req", 32'(imem.imem_req), 32'h0);
        chk("skid_full", 32'(u_dut.u_skid.valid_o), 32'h1);
        stall = STALL_NONE;
        step();
        chk("drain_pc", PC_if, 32'hC);
        chk("drain_inst", inst_if, 32'h00A0_0093);
        chk("drain_addr", imem.imem_addr, 32'h10);
        chk("drain_req", 32'(imem.imem_req), 32'h1);
        // redirect while waiting: stale response dropped
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        step();
        branch_taken = 1'b0;
        chk("br_wait_req", 32'(imem.imem_req), 32'h0);
        chk("br_inst", inst_if, 32'h0);
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem.imem_rvalid = 1'b0;
        chk("drop_inst", inst_if, 32'h0);
        chk("drop_pc", PC_if, 32'hC);
        chk("br_addr", imem.imem_addr, 32'h100);
        chk("br_req", 32'(imem.imem_req), 32'h1);
        // branch and response together under branch stall
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt    = 1'b0;
        stall            = STALL_BRANCH;
        branch_taken     = 1'b1;
        branch_target    = 32'h200;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hBEEF_0001;
        step();
        branch_taken     = 1'b0;
        imem.imem_rvalid = 1'b0;
        chk("co_addr", imem.imem_addr, 32'h200);
        chk("co_inst", inst_if, 32'h0);
        chk("co_hold_req", 32'(imem.imem_req), 32'h0);
        chk("co_skid", 32'(u_dut.u_skid.valid_o), 32'h0);
        stall = STALL_NONE;
        #1;
        chk("co_req", 32'(imem.imem_req), 32'h1);
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h0000_0011;
        step();
        imem.imem_rvalid = 1'b0;
        chk("tgt_pc", PC_if, 32'h200);
        chk("tgt_inst", inst_if, 32'h0000_0011);
        // grant withheld: request held stable
        for (int i = 0; i < 5; i++) begin
            step();
            chk("nognt_req", 32'(imem.imem_req), 32'h1);
            chk("nognt_addr", imem.imem_addr, 32'h204);
        end
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        // asynchronous reset mid-wait, then a late response
        #1 rst = 1'b0;
        #1;
        chk("arst_pc", PC_if, 32'h0);
        chk("arst_inst", inst_if, 32'h0);
        chk("arst_req", 32'(imem.imem_req), 32'h0);
        #2 rst = 1'b1;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hBAD0_0BAD;
        step();
        imem.imem_rvalid = 1'b0;
        chk("late_inst", inst_if, 32'h0);
        chk("late_pc", PC_if, 32'h0);
        chk("late_addr", imem.imem_addr, 32'h0);
        chk("late_req", 32'(imem.imem_req), 32'h1);
`ifdef IF_MISALIGN_CHK_EN
        branch_taken  = 1'b1;
        branch_target = 32'h102;
        step();
        branch_taken = 1'b0;
        chk("mis_flag", 32'(fetch_misalign), 32'h1);
        chk("mis_addr", imem.imem_addr, 32'h100);
        step();
        chk("mis_clear", 32'(fetch_misalign), 32'h0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
